// File: rtl/io_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// io_write_arbiter_pkg
// Shared definitions for the peripheral write arbiter:
//   - FSM state encoding used by io_write_arbiter
//   - requester index constants (bit positions in the request/win vectors)
//   - base address of the seven-segment digit register
//   - helper that sizes the write/gap cycle counter
// -----------------------------------------------------------------------------
package io_write_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

   // Requester 0 is the CPU store port, requester 1 the debug/self-test writer.
   localparam int REQ_CPU = 0;
   localparam int REQ_DBG = 1;

   // Seven-segment digit register; writes are passed through undecoded, the
   // constant is here so peripheral decode shares one definition.
   localparam logic [11:0] DIGIT_ADDR = 12'h000;

   // One counter serves both the WRITE and GAP phases, so it must hold the
   // larger of the two lengths. Never narrower than one bit.
   function automatic int cnt_width(input int wr_cycles, input int gap_cycles);
      int longest;
      longest = (wr_cycles > gap_cycles) ? wr_cycles : gap_cycles;
      if (longest < 1) begin
         return 1;
      end
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/io_write_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Purely combinational two-way round-robin picker.
// Ports:
//   req   [1:0]  request vector (bit i = requester i)
//   ptr          index of the requester that wins when both request
//   win   [1:0]  one-hot winner (all zero when no request)
//   valid        at least one request present
// -----------------------------------------------------------------------------
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] win,
   output logic       valid
);

   always_comb begin
      valid = |req;
      // A lone request wins outright; the pointer only breaks ties.
      win   = req;
      if (req == 2'b11) begin
         win = ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/io_write_arbiter.sv
// -----------------------------------------------------------------------------
// io_write_arbiter
// Round-robin arbiter sharing the single peripheral write bus between the CPU
// store port (m0) and the debug/self-test writer (m1). Each accepted request
// becomes one registered write pulse of WR_CYCLES cycles on the bus, followed
// by GAP_CYCLES forced idle cycles before the next arbitration.
//
// Parameters:
//   ADDR_W      peripheral address width
//   DATA_W      write data width
//   WR_CYCLES   cycles bus_wen is held per write (>=1)
//   GAP_CYCLES  idle cycles after each write (>=0)
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   m0_req/addr/wdata      requester 0 (CPU) level request and payload
//   m0_gnt                 one-cycle pulse: requester 0 write accepted
//   m1_req/addr/wdata      requester 1 (debug) level request and payload
//   m1_gnt                 one-cycle pulse: requester 1 write accepted
//   bus_wen/addr/wdata     shared peripheral write bus (qualify on bus_wen)
//   busy                   high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module io_write_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int WR_CYCLES  = 1,
   parameter int GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              bus_wen,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              busy
);

   import io_write_arbiter_pkg::*;

   localparam int CNT_W = cnt_width(WR_CYCLES, GAP_CYCLES);

   // Terminal counts of the two timed phases. The GAP value is unused when
   // GAP_CYCLES is 0 (the FSM never enters GAP), so clamp it to stay in range.
   localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   arb_state_t        state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              ptr_reg;

   logic [1:0]        req_vec;
   logic [1:0]        win;
   logic              win_valid;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   assign req_vec[REQ_CPU] = m0_req;
   assign req_vec[REQ_DBG] = m1_req;

   rr_pick2 u_pick (
      .req   (req_vec),
      .ptr   (ptr_reg),
      .win   (win),
      .valid (win_valid)
   );

   // Winner payload; only consumed in IDLE when win_valid is set.
   assign win_addr  = win[REQ_DBG] ? m1_addr  : m0_addr;
   assign win_wdata = win[REQ_DBG] ? m1_wdata : m0_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         ptr_reg   <= 1'b0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         bus_wen   <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         // Grants are single-cycle pulses raised only on the IDLE->WRITE step.
         m0_gnt <= 1'b0;
         m1_gnt <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (win_valid) begin
                  state_reg <= WRITE;
                  cnt_reg   <= '0;
                  m0_gnt    <= win[REQ_CPU];
                  m1_gnt    <= win[REQ_DBG];
                  bus_wen   <= 1'b1;
                  bus_addr  <= win_addr;
                  bus_wdata <= win_wdata;
                  busy      <= 1'b1;
                  // Hand priority to the loser: if the CPU won, point at debug.
                  ptr_reg   <= win[REQ_CPU];
               end
            end

            WRITE: begin
               if (cnt_reg == WR_LAST) begin
                  bus_wen <= 1'b0;
                  cnt_reg <= '0;
                  if (GAP_CYCLES > 0) begin
                     state_reg <= GAP;
                  end else begin
                     state_reg <= IDLE;
                     busy      <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            GAP: begin
               if (cnt_reg == GAP_LAST) begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
                  busy      <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            default: begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               bus_wen   <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/io_write_arbiter.md
Name: io_write_arbiter

Overview:
Round-robin arbiter that shares the single peripheral write bus (addr/wen/wdata) of the seven-segment digit interface, and of any other memory-mapped output peripheral, between two write requesters. Requester 0 is the CPU store port; requester 1 is the debug/self-test writer. Each accepted request becomes one registered write pulse of programmable length on the shared bus. The block sits between the requesters and the peripheral decode.

Parameters:
ADDR_W, 12, peripheral address width
DATA_W, 32, write data width
WR_CYCLES, 1, cycles bus_wen is held per write (>=1)
GAP_CYCLES, 0, idle cycles forced after each write before the next arbitration (>=0)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
m0_req  in  1  requester 0 write request (level)
m0_addr  in  ADDR_W  requester 0 address, stable while m0_req=1 until grant
m0_wdata  in  DATA_W  requester 0 data, stable while m0_req=1 until grant
m0_gnt  out  1  one-cycle pulse: requester 0 write accepted
m1_req  in  1  requester 1 write request
m1_addr  in  ADDR_W  requester 1 address
m1_wdata  in  DATA_W  requester 1 data
m1_gnt  out  1  one-cycle pulse: requester 1 write accepted
bus_wen  out  1  shared bus write enable
bus_addr  out  ADDR_W  shared bus address
bus_wdata  out  DATA_W  shared bus data
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset: all outputs 0. FSM enters IDLE, priority pointer points to requester 0, counters are 0. Reset is asynchronous: a write in flight is dropped and bus_wen falls immediately.
- FSM states: IDLE, WRITE, GAP.
- IDLE: requests are sampled at each edge.
  - No req: stay in IDLE.
  - Any req: select a winner, load bus_addr/bus_wdata from the winner, and go to WRITE.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high: the requester named by the pointer wins.
  - After every grant the pointer moves to the non-winner. Strict alternation under constant contention; neither requester is starved.
- WRITE: entered at edge E.
  - Winner's gnt=1 for exactly the first cycle after E.
  - bus_wen=1 for WR_CYCLES cycles after E. Cycle counter runs from 0 to WR_CYCLES-1.
  - bus_addr/bus_wdata hold their values during WRITE.
  - Requests are ignored in WRITE.
  - On the last write cycle: go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: bus_wen=0 for GAP_CYCLES cycles, requests ignored, then go to IDLE.
- bus_addr/bus_wdata keep their last values outside WRITE. Peripherals qualify on bus_wen only.
- Latency: req sampled high at edge E-1 means gnt and bus_wen are high in the cycle after E... precisely, a req sampled at edge E (FSM in IDLE) gives gnt and bus_wen high in the cycle following E. That is 1 cycle of latency.
- Throughput: one write per 1+WR_CYCLES+GAP_CYCLES cycles.
- Requester protocol:
  - After seeing gnt, a requester either drops req or presents its next address/data by the following edge.
  - A req held unchanged after gnt is treated as a new write; this is legal.
- The arbiter does not decode addresses; all writes pass through unchanged.
- m0_gnt and m1_gnt are never high together. At most one gnt per write.
- Req deasserted before grant: the request is withdrawn with no side effect.
- Width rule: the cycle counters are sized to $clog2 of max(WR_CYCLES, GAP_CYCLES)+1.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, WRITE=2'd1, GAP=2'd2
  - Requester index constants REQ_CPU=0, REQ_DBG=1
  - Peripheral base address constant DIGIT_ADDR=12'h000
- Sub-module rr_pick2: a purely combinational two-way round-robin picker. Inputs are req[1:0] and ptr; outputs are a one-hot win and a valid flag. It is instantiated once.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Reset hold: rst=1 with both reqs high -> all outputs 0. After rst falls, the first grant goes to m0.
- Single write, defaults: m0_req with addr=0x000, data=0x12345678 sampled at edge E -> next cycle m0_gnt=1, bus_wen=1, bus_addr=0x000, bus_wdata=0x12345678. The cycle after that, bus_wen=0 and busy=0.
- Contention, defaults: both reqs held high for 8 cycles -> grants alternate m0, m1, m0, m1 on alternating cycles. bus_wdata tracks the winner's data. Never both gnts high.
- WR_CYCLES=3, GAP_CYCLES=2: m1 write of 0xDEADBEEF -> bus_wen high for exactly 3 cycles with data stable, then 2 idle cycles with busy=1. A pending m0 request is granted on the 6th cycle after acceptance.
- Reset mid-write: WR_CYCLES=3, rst asserted in the 2nd write cycle -> bus_wen drops in the same cycle (async). After release, FSM is IDLE and the pointer is back at m0.
- Withdrawn request: m1_req pulsed high for one cycle while the FSM is in WRITE for m0 -> no m1 grant and no extra bus write.
